// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants and types for the Pong match sequencer
package pong_pkg;
  localparam int SCORE_W  = 3;
  localparam int CENTER_X = 320;
  localparam int CENTER_Y = 240;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [2:0]         state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SERVE     = 3'd1;
  localparam state_t ST_PLAY      = 3'd2;
  localparam state_t ST_POINT     = 3'd3;
  localparam state_t ST_GAME_OVER = 3'd4;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Counter value on the last tick of an interval lasting 'frames' ticks.
  function automatic logic [7:0] term_count(input int frames);
    return 8'(frames - 1);
  endfunction
endpackage

// File: rtl/pong_match_ctrl_if.sv
// rtl/pong_match_ctrl_if.sv - physics/renderer side signals of the match sequencer
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic       frame_tick;
  logic       serve_btn;
  logic       miss_l;
  logic       miss_r;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  score_t     score1;
  score_t     score2;
  logic       overlay_on;
  logic       blink;
  logic [1:0] winner;

  modport master (
    output frame_tick, serve_btn, miss_l, miss_r,
    input  ball_reset, ball_run, serve_dir, score1, score2, overlay_on, blink, winner
  );

  modport slave (
    input  frame_tick, serve_btn, miss_l, miss_r,
    output ball_reset, ball_run, serve_dir, score1, score2, overlay_on, blink, winner
  );
endinterface

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - 8-bit frame tick counter with clear and terminal-count flag
module pong_frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       at_limit
);
  logic [7:0] count;

  // Clear outranks tick so a tick on a state-entry edge is not counted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign at_limit = (count == limit);
endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - serve/play/point/game-over sequencer owning scores and winner
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int BLINK_FRAMES = 30
) (
  input logic              CLOCK_50,
  input logic              RESET,
  pong_match_ctrl_if.slave bus
);
  localparam score_t WIN = score_t'(WIN_SCORE);

  state_t     state;
  state_t     state_n;
  logic [7:0] limit;
  logic       at_limit;
  logic       fin;
  logic       clr;

  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  score_t     score1;
  score_t     score2;
  logic       overlay_on;
  logic       blink;
  logic [1:0] winner;

  always_comb begin
    limit = 8'd0;
    case (state)
      ST_SERVE:     limit = term_count(SERVE_FRAMES);
      ST_POINT:     limit = term_count(POINT_FRAMES);
      ST_GAME_OVER: limit = term_count(BLINK_FRAMES);
      default:      limit = 8'd0;
    endcase
  end

  assign fin = bus.frame_tick && at_limit;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (bus.frame_tick && bus.serve_btn) state_n = ST_SERVE;
      ST_SERVE:     if (fin) state_n = ST_PLAY;
      ST_PLAY:      if (bus.miss_l || bus.miss_r) state_n = ST_POINT;
      ST_POINT: begin
        if (fin) begin
          state_n = (score1 == WIN || score2 == WIN) ? ST_GAME_OVER : ST_IDLE;
        end
      end
      ST_GAME_OVER: state_n = ST_GAME_OVER;
      default:      state_n = ST_IDLE;
    endcase
  end

  // The timer restarts on every state change and on each blink half-period.
  assign clr = (state_n != state) || (state == ST_GAME_OVER && fin);

  pong_frame_timer u_timer (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .clr      (clr),
    .tick     (bus.frame_tick),
    .limit    (limit),
    .at_limit (at_limit)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= ST_IDLE;
      score1     <= '0;
      score2     <= '0;
      ball_reset <= 1'b1;
      ball_run   <= 1'b0;
      serve_dir  <= 1'b0;
      overlay_on <= 1'b1;
      blink      <= 1'b0;
      winner     <= WINNER_NONE;
    end else begin
      state      <= state_n;
      ball_reset <= (state_n != ST_PLAY);
      ball_run   <= (state_n == ST_PLAY);
      overlay_on <= (state_n == ST_IDLE) || (state_n == ST_POINT) || (state_n == ST_GAME_OVER);
      // A simultaneous miss on both goals is a let: nobody scores.
      if (state == ST_PLAY) begin
        if (bus.miss_l && !bus.miss_r) begin
          score2    <= score2 + score_t'(1);
          serve_dir <= 1'b0;
        end else if (bus.miss_r && !bus.miss_l) begin
          score1    <= score1 + score_t'(1);
          serve_dir <= 1'b1;
        end
      end
      if (state == ST_POINT && fin) begin
        if (score1 == WIN) begin
          winner <= WINNER_P1;
        end else if (score2 == WIN) begin
          winner <= WINNER_P2;
        end
      end
      if (state == ST_GAME_OVER && fin) begin
        blink <= ~blink;
      end
    end
  end

  assign bus.ball_reset = ball_reset;
  assign bus.ball_run   = ball_run;
  assign bus.serve_dir  = serve_dir;
  assign bus.score1     = score1;
  assign bus.score2     = score2;
  assign bus.overlay_on = overlay_on;
  assign bus.blink      = blink;
  assign bus.winner     = winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed scoreboard bench for pong_match_ctrl
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE    (2),
    .SERVE_FRAMES (4),
    .POINT_FRAMES (3),
    .BLINK_FRAMES (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       ball_reset;
    logic       ball_run;
    logic       serve_dir;
    logic [2:0] score1;
    logic [2:0] score2;
    logic       overlay_on;
    logic       blink;
    logic [1:0] winner;
  } exp_t;

  localparam int I = 0, S = 1, P = 2, T = 3, G = 4;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic t, input logic s, input logic ml, input logic mr);
    @(negedge CLOCK_50);
    RESET          = rst;
    bus.frame_tick = t;
    bus.serve_btn  = s;
    bus.miss_l     = ml;
    bus.miss_r     = mr;
  endtask

  // Expected outputs for the state the DUT should be in after this cycle.
  task automatic push(input int st, input logic sd, input logic [2:0] s1, input logic [2:0] s2,
                      input logic bl, input logic [1:0] w);
    exp_t e;
    e.ball_reset = (st != P);
    e.ball_run   = (st == P);
    e.overlay_on = (st == I) || (st == T) || (st == G);
    e.serve_dir  = sd;
    e.score1     = s1;
    e.score2     = s2;
    e.blink      = bl;
    e.winner     = w;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".ball_reset"}, {7'd0, bus.ball_reset}, {7'd0, e.ball_reset});
      cmp({tag, ".ball_run"},   {7'd0, bus.ball_run},   {7'd0, e.ball_run});
      cmp({tag, ".serve_dir"},  {7'd0, bus.serve_dir},  {7'd0, e.serve_dir});
      cmp({tag, ".score1"},     {5'd0, bus.score1},     {5'd0, e.score1});
      cmp({tag, ".score2"},     {5'd0, bus.score2},     {5'd0, e.score2});
      cmp({tag, ".overlay_on"}, {7'd0, bus.overlay_on}, {7'd0, e.overlay_on});
      cmp({tag, ".blink"},      {7'd0, bus.blink},      {7'd0, e.blink});
      cmp({tag, ".winner"},     {6'd0, bus.winner},     {6'd0, e.winner});
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic t, input logic s,
                      input logic ml, input logic mr, input int st, input logic sd,
                      input logic [2:0] s1, input logic [2:0] s2, input logic bl,
                      input logic [1:0] w);
    drive(rst, t, s, ml, mr);
    push(st, sd, s1, s2, bl, w);
    pop_check(tag);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.serve_btn  = 1'b0;
    bus.miss_l     = 1'b0;
    bus.miss_r     = 1'b0;

    step("reset",      1, 0, 0, 0, 0, I, 0, 0, 0, 0, 0);
    step("idle_notick",0, 0, 1, 0, 0, I, 0, 0, 0, 0, 0);
    // serve and hold for four ticks
    step("serve",      0, 1, 1, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv_t1",     0, 1, 1, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv_gap",    0, 0, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv_t2",     0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv_t3",     0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv_t4",     0, 1, 0, 0, 0, P, 0, 0, 0, 0, 0);
    step("play_hold",  0, 1, 0, 0, 0, P, 0, 0, 0, 0, 0);
    // point to P1
    step("miss_r",     0, 0, 0, 0, 1, T, 1, 1, 0, 0, 0);
    step("pt_t1",      0, 1, 0, 0, 0, T, 1, 1, 0, 0, 0);
    step("pt_t2",      0, 1, 0, 0, 0, T, 1, 1, 0, 0, 0);
    step("pt_t3",      0, 1, 0, 0, 0, I, 1, 1, 0, 0, 0);
    // misses outside PLAY are ignored
    step("idle_miss",  0, 0, 0, 1, 0, I, 1, 1, 0, 0, 0);
    step("serve2",     0, 1, 1, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv_miss",   0, 0, 0, 1, 0, S, 1, 1, 0, 0, 0);
    step("srv2_t1",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv2_t2",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv2_t3",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv2_t4",    0, 1, 0, 0, 0, P, 1, 1, 0, 0, 0);
    // let
    step("let",        0, 0, 0, 1, 1, T, 1, 1, 0, 0, 0);
    step("pt_miss",    0, 0, 0, 1, 0, T, 1, 1, 0, 0, 0);
    step("let_t1",     0, 1, 0, 0, 0, T, 1, 1, 0, 0, 0);
    step("let_t2",     0, 1, 0, 0, 0, T, 1, 1, 0, 0, 0);
    step("let_t3",     0, 1, 0, 0, 0, I, 1, 1, 0, 0, 0);
    // miss coincident with tick: scored once, tick not counted
    step("serve3",     0, 1, 1, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv3_t1",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv3_t2",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv3_t3",    0, 1, 0, 0, 0, S, 1, 1, 0, 0, 0);
    step("srv3_t4",    0, 1, 0, 0, 0, P, 1, 1, 0, 0, 0);
    step("miss_l_tick",0, 1, 0, 1, 0, T, 0, 1, 1, 0, 0);
    step("mlt_t1",     0, 1, 0, 0, 0, T, 0, 1, 1, 0, 0);
    step("mlt_t2",     0, 1, 0, 0, 0, T, 0, 1, 1, 0, 0);
    step("mlt_t3",     0, 1, 0, 0, 0, I, 0, 1, 1, 0, 0);
    // P2 reaches the winning score
    step("serve4",     0, 1, 1, 0, 0, S, 0, 1, 1, 0, 0);
    step("srv4_t1",    0, 1, 0, 0, 0, S, 0, 1, 1, 0, 0);
    step("srv4_t2",    0, 1, 0, 0, 0, S, 0, 1, 1, 0, 0);
    step("srv4_t3",    0, 1, 0, 0, 0, S, 0, 1, 1, 0, 0);
    step("srv4_t4",    0, 1, 0, 0, 0, P, 0, 1, 1, 0, 0);
    step("win_miss",   0, 0, 0, 1, 0, T, 0, 1, 2, 0, 0);
    step("win_t1",     0, 1, 0, 0, 0, T, 0, 1, 2, 0, 0);
    step("win_t2",     0, 1, 0, 0, 0, T, 0, 1, 2, 0, 0);
    step("win_t3",     0, 1, 0, 0, 0, G, 0, 1, 2, 0, 2);
    // blink every two ticks; serve and misses ignored
    step("go_t1",      0, 1, 0, 0, 0, G, 0, 1, 2, 0, 2);
    step("go_t2",      0, 1, 0, 0, 0, G, 0, 1, 2, 1, 2);
    step("go_serve",   0, 1, 1, 0, 0, G, 0, 1, 2, 1, 2);
    step("go_miss_t",  0, 1, 0, 1, 1, G, 0, 1, 2, 0, 2);
    step("go_nt_all",  0, 0, 1, 1, 1, G, 0, 1, 2, 0, 2);
    step("go_t5",      0, 1, 0, 0, 0, G, 0, 1, 2, 0, 2);
    step("go_t6",      0, 1, 0, 0, 0, G, 0, 1, 2, 1, 2);
    // reset mid-GAME_OVER and mid-SERVE
    step("rst_go",     1, 1, 0, 0, 0, I, 0, 0, 0, 0, 0);
    step("serve5",     0, 1, 1, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv5_t1",    0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv5_t2",    0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("rst_srv",    1, 1, 1, 0, 0, I, 0, 0, 0, 0, 0);
    step("serve6",     0, 1, 1, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv6_t1",    0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv6_t2",    0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv6_t3",    0, 1, 0, 0, 0, S, 0, 0, 0, 0, 0);
    step("srv6_t4",    0, 1, 0, 0, 0, P, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
